// File: rtl/maze_tile_painter.sv
// rtl/maze_tile_painter.sv - tile/clear raster writer for the 270x270 framebuffer; optional border via TILE_BORDER_EN
module maze_tile_painter #(
  parameter int SCREEN_W  = 270,
  parameter int SCREEN_H  = 270,
  parameter int TILE_SIZE = 54,
  parameter int GRID_COLS = 5,
  parameter int GRID_ROWS = 5,
  parameter int ADDR_W    = 17,
  parameter logic [7:0] BORDER_COLOR = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_clear,
  input  logic [2:0]        req_col,
  input  logic [2:0]        req_row,
  input  logic [7:0]        req_color,
  output logic [ADDR_W-1:0] w_addr,
  output logic [7:0]        w_data,
  output logic              w_en,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, PAINT, DONE} state_t;
  state_t state, state_nxt;

`ifdef TILE_BORDER_EN
  localparam logic BORDER_ON = 1'b1;
`else
  localparam logic BORDER_ON = 1'b0;
`endif

  localparam logic [8:0]        TILE_LAST     = 9'(TILE_SIZE - 1);
  localparam logic [8:0]        SCR_X_LAST    = 9'(SCREEN_W - 1);
  localparam logic [8:0]        SCR_Y_LAST    = 9'(SCREEN_H - 1);
  localparam logic [ADDR_W-1:0] TILE_ROW_STEP = ADDR_W'(SCREEN_W - TILE_SIZE + 1);
  localparam logic [ADDR_W-1:0] ROW_PITCH     = ADDR_W'(TILE_SIZE * SCREEN_W);
  localparam logic [ADDR_W-1:0] COL_PITCH     = ADDR_W'(TILE_SIZE);

  logic [8:0]        x, y;
  logic [8:0]        x_last, y_last, x_nxt, y_nxt;
  logic              clear_r, err_r;
  logic [7:0]        color_r;
  logic              accept, out_of_range, row_end, last_pixel;
  logic [ADDR_W-1:0] origin, addr_step;

  // Border pixels sit on the tile-local edge; clears never get a border
  function automatic logic [7:0] pixel_color(input logic [8:0] px, input logic [8:0] py,
                                             input logic is_clear, input logic [7:0] fill);
    logic on_edge;
    on_edge = (px == 9'd0) || (px == TILE_LAST) || (py == 9'd0) || (py == TILE_LAST);
    return (BORDER_ON && !is_clear && on_edge) ? BORDER_COLOR : fill;
  endfunction

  // Request decode and raster stepping; the multiply is only used once per request
  always_comb begin
    accept       = req_valid && (state == IDLE);
    out_of_range = !req_clear && ((int'(req_col) >= GRID_COLS) || (int'(req_row) >= GRID_ROWS));
    origin       = ADDR_W'(req_row) * ROW_PITCH + ADDR_W'(req_col) * COL_PITCH;
    x_last       = clear_r ? SCR_X_LAST : TILE_LAST;
    y_last       = clear_r ? SCR_Y_LAST : TILE_LAST;
    row_end      = (x == x_last);
    last_pixel   = row_end && (y == y_last);
    x_nxt        = row_end ? 9'd0 : x + 9'd1;
    y_nxt        = row_end ? y + 9'd1 : y;
    addr_step    = (row_end && !clear_r) ? TILE_ROW_STEP : ADDR_W'(1);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and the state-decoded handshake/strobe outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    w_en      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = out_of_range ? DONE : PAINT;
      end
      PAINT: begin
        w_en = 1'b1;
        if (last_pixel) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        err       = err_r;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the request and walk the address/colour one pixel per clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x       <= 9'd0;
      y       <= 9'd0;
      clear_r <= 1'b0;
      err_r   <= 1'b0;
      color_r <= 8'h00;
      w_addr  <= '0;
      w_data  <= 8'h00;
    end else if (accept) begin
      x       <= 9'd0;
      y       <= 9'd0;
      clear_r <= req_clear;
      color_r <= req_color;
      err_r   <= out_of_range;
      if (!out_of_range) begin
        w_addr <= req_clear ? '0 : origin;
        w_data <= pixel_color(9'd0, 9'd0, req_clear, req_color);
      end
    end else if (state == PAINT && !last_pixel) begin
      x      <= x_nxt;
      y      <= y_nxt;
      w_addr <= w_addr + addr_step;
      w_data <= pixel_color(x_nxt, y_nxt, clear_r, color_r);
    end
  end

endmodule

// File: tb/tb_maze_tile_painter.sv
// tb/tb_maze_tile_painter.sv - self-checking bench for maze_tile_painter
`timescale 1ns/1ps
module tb_maze_tile_painter;
  localparam int SW = 270, SH = 270, TS = 54, GC = 5, GR = 5, AW = 17;
  localparam logic [7:0] BC = 8'hFF;
`ifdef TILE_BORDER_EN
  localparam bit BON = 1'b1;
`else
  localparam bit BON = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b1;
  logic          req_valid = 1'b0, req_clear = 1'b0;
  logic [2:0]    req_col = 3'd0, req_row = 3'd0;
  logic [7:0]    req_color = 8'h00;
  logic          req_ready, w_en, done, err;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_data;

  maze_tile_painter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_clear(req_clear), .req_col(req_col), .req_row(req_row), .req_color(req_color),
    .w_addr(w_addr), .w_data(w_data), .w_en(w_en), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic wen; logic [AW-1:0] addr; logic [7:0] data; logic dn; logic er; } rec_t;
  rec_t exp_q[$];

  int cur_id = 0, cyc = 0, tests = 0, fails = 0;
  int acc_cyc[16]   = '{default: 0};
  int done_cyc[16]  = '{default: 0};
  int st_cnt[16]    = '{default: 0};
  int st_first[16]  = '{default: -1};
  int st_last[16]   = '{default: -1};
  int st_saw54[16]  = '{default: 0};
  int st_saw270[16] = '{default: 0};
  int st_done[16]   = '{default: 0};
  int st_err[16]    = '{default: 0};
  int st_bad[16]    = '{default: 0};
  int st_badc[16]   = '{default: 0};
  int st_da[16]     = '{default: -1};
  int st_db[16]     = '{default: -1};

  // Model colour rule: border on tile-local edges only when the feature is built in
  function automatic logic [7:0] model_pix(int lx, int ly, logic [7:0] c);
    bit edge_px;
    edge_px = (lx == 0) || (lx == TS - 1) || (ly == 0) || (ly == TS - 1);
    return (BON && edge_px) ? BC : c;
  endfunction

  // Model: on acceptance, lay out the full expected output trace of the request
  always @(posedge clk or posedge reset) begin
    if (reset) exp_q.delete();
    else if (exp_q.size() != 0) void'(exp_q.pop_front());
    else if (req_valid) begin
      bit oob;
      oob = !req_clear && (int'(req_col) >= GC || int'(req_row) >= GR);
      if (cur_id < 15) cur_id++;
      acc_cyc[cur_id] = cyc;
      if (req_clear) begin
        for (int a = 0; a < SW * SH; a++) exp_q.push_back({1'b1, AW'(a), req_color, 1'b0, 1'b0});
      end else if (!oob) begin
        for (int yy = 0; yy < TS; yy++)
          for (int xx = 0; xx < TS; xx++)
            exp_q.push_back({1'b1, AW'((int'(req_row) * TS + yy) * SW + int'(req_col) * TS + xx),
                             model_pix(xx, yy, req_color), 1'b0, 1'b0});
      end
      exp_q.push_back({1'b0, AW'(0), 8'h00, 1'b1, oob});
    end
  end

  // Compare DUT against the model every cycle and gather per-request observations
  always @(negedge clk) begin
    rec_t e;
    bit   bad;
    cyc++;
    e   = (exp_q.size() != 0) ? exp_q[0] : '0;
    bad = (w_en !== e.wen) || (done !== e.dn) || (err !== e.er) || (req_ready !== (exp_q.size() == 0));
    if (e.wen && ((w_addr !== e.addr) || (w_data !== e.data))) bad = 1'b1;
    if (bad) begin
      if (st_bad[cur_id] == 0) st_badc[cur_id] = cyc;
      st_bad[cur_id]++;
    end
    if (w_en === 1'b1) begin
      if (st_cnt[cur_id] == 0) st_first[cur_id] = int'(w_addr);
      st_last[cur_id] = int'(w_addr);
      st_cnt[cur_id]++;
      if (int'(w_addr) == 54)    st_saw54[cur_id]++;
      if (int'(w_addr) == 270)   st_saw270[cur_id]++;
      if (int'(w_addr) == 58536) st_da[cur_id] = int'(w_data);
      if (int'(w_addr) == 58807) st_db[cur_id] = int'(w_data);
    end
    if (done === 1'b1) begin
      st_done[cur_id]++;
      done_cyc[cur_id] = cyc;
      if (err === 1'b1) st_err[cur_id]++;
    end
  end

  task automatic chk(string name, longint act, longint expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic send(bit clr, logic [2:0] col, logic [2:0] row, logic [7:0] c, bit hold, output int id);
    int start, n;
    start = cur_id;
    n = 0;
    req_clear = clr; req_col = col; req_row = row; req_color = c; req_valid = 1'b1;
    while (cur_id == start && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    if (cur_id == start) chk("accept_timeout", 0, 1);
    id = cur_id;
    if (!hold) begin
      req_valid = 1'b0; req_col = 3'd7; req_row = 3'd7; req_color = 8'h5A; req_clear = 1'b1;
    end
  endtask

  task automatic wait_done(int id);
    int n;
    n = 0;
    while (st_done[id] == 0 && n < 80000) begin
      @(negedge clk); #1;
      n++;
    end
    if (st_done[id] == 0) chk("done_timeout", 0, 1);
    @(negedge clk); #1;
  endtask

  task automatic chk_stream(string name, int id);
    tests++;
    if (st_bad[id] != 0) begin
      fails++;
      $display("FAIL %s: %0d cycles differ from model, first at cycle %0d, required 0", name, st_bad[id], st_badc[id]);
    end
  endtask

  initial begin
    int id1, id2, id3, id4, id5, id6, n;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_ready", req_ready, 1);
    chk("reset_wen", w_en, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_addr", w_addr, 0);
    @(negedge clk); #1;

    // Tile (0,0) with (4,4) queued behind it, valid held across completion
    send(1'b0, 3'd0, 3'd0, 8'hE0, 1'b1, id1);
    send(1'b0, 3'd4, 3'd4, 8'h1C, 1'b0, id2);
    chk("t00_count", st_cnt[id1], 2916);
    chk("t00_first", st_first[id1], 0);
    chk("t00_last", st_last[id1], 14363);
    chk("t00_addr54", st_saw54[id1], 0);
    chk("t00_addr270", st_saw270[id1], 1);
    chk("t00_done_lat", done_cyc[id1] - acc_cyc[id1], 2917);
    chk("t00_err", st_err[id1], 0);
    chk("b2b_spacing", acc_cyc[id2] - acc_cyc[id1], 2918);
    chk_stream("t00_stream", id1);
    wait_done(id2);
    chk("t44_count", st_cnt[id2], 2916);
    chk("t44_first", st_first[id2], 58536);
    chk("t44_last", st_last[id2], 72899);
    chk("t44_data_corner", st_da[id2], BON ? 255 : 28);
    chk("t44_data_inner", st_db[id2], 28);
    chk_stream("t44_stream", id2);

    // Out-of-range tile
    send(1'b0, 3'd5, 3'd0, 8'h33, 1'b0, id3);
    wait_done(id3);
    chk("oob_count", st_cnt[id3], 0);
    chk("oob_done", st_done[id3], 1);
    chk("oob_err", st_err[id3], 1);
    chk("oob_done_lat", done_cyc[id3] - acc_cyc[id3], 1);
    chk_stream("oob_stream", id3);

    // Full-screen clear
    send(1'b1, 3'd0, 3'd0, 8'h00, 1'b0, id4);
    wait_done(id4);
    chk("clr_count", st_cnt[id4], 72900);
    chk("clr_first", st_first[id4], 0);
    chk("clr_last", st_last[id4], 72899);
    chk("clr_err", st_err[id4], 0);
    chk_stream("clr_stream", id4);

    // Reset mid-paint of tile (1,2)
    send(1'b0, 3'd1, 3'd2, 8'h4C, 1'b0, id5);
    n = 0;
    while (st_cnt[id5] < 100 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rst_reach100", st_cnt[id5], 100);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_wen", w_en, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", req_ready, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_no_done", st_done[id5], 0);
    chk("rst_writes", st_cnt[id5], 100);
    chk_stream("rst_stream", id5);

    send(1'b0, 3'd2, 3'd1, 8'hA5, 1'b0, id6);
    wait_done(id6);
    chk("t21_first", st_first[id6], 14688);
    chk("t21_count", st_cnt[id6], 2916);
    chk("t21_last", st_last[id6], 29051);
    chk_stream("t21_stream", id6);
    chk_stream("idle_stream", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/maze_tile_painter.md
Name: maze_tile_painter

Overview:
- Write-side producer for the 270x270, 8-bit-per-pixel dual-port framebuffer RAM.
- Accepts tile paint requests (grid column, grid row, colour) from the maze/robot logic.
- Expands each request into a raster of single-pixel writes on the RAM write port: one pixel per clock, no gaps.
- Also supports a full-screen clear command. The VGA read side is untouched.

Parameters:
SCREEN_W, 270, framebuffer width in pixels
SCREEN_H, 270, framebuffer height in pixels
TILE_SIZE, 54, tile edge in pixels (square tiles)
GRID_COLS, 5, tiles per row; GRID_COLS*TILE_SIZE <= SCREEN_W
GRID_ROWS, 5, tiles per column; GRID_ROWS*TILE_SIZE <= SCREEN_H
ADDR_W, 17, framebuffer address width; must cover SCREEN_W*SCREEN_H-1
BORDER_COLOR, 8'hFF, border pixel colour (used only with TILE_BORDER_EN)

Ports:
clk  input  1  write-domain clock, shared with the RAM write port
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_clear  input  1  1 = clear the whole screen to req_color; col/row ignored
req_col  input  3  tile column index
req_row  input  3  tile row index
req_color  input  8  fill colour (RRRGGGBB)
w_addr  output  ADDR_W  RAM write address
w_data  output  8  RAM write data
w_en  output  1  RAM write enable
done  output  1  one-cycle pulse when a request completes
err  output  1  one-cycle pulse, concurrent with done, for an out-of-range tile

Behaviour:
- Reset state: state=IDLE, w_en=0, w_addr=0, w_data=0, done=0, err=0, req_ready=1.
- Reset is asynchronous: asserting it mid-operation drops w_en in the same cycle and abandons the request. No resume.
- FSM states: IDLE, PAINT, DONE.
- req_ready=1 only in IDLE. A request is accepted on a clock edge where req_valid & req_ready. col, row, colour and clear are latched at acceptance.
- IDLE -> PAINT on acceptance of a valid request.
- IDLE -> DONE on acceptance of an out-of-range tile (req_col>=GRID_COLS or req_row>=GRID_ROWS, req_clear=0). No writes are issued; err pulses with done.
- Tile origin = (req_row*TILE_SIZE)*SCREEN_W + req_col*TILE_SIZE.
- In the cycle after acceptance: w_en=1, w_addr=origin.
- Raster order: x increments first; y increments at the end of each row.
- Address update: +1 within a row; +(SCREEN_W-TILE_SIZE+1) at a row end. No multiplier in the per-pixel path.
- A tile produces exactly TILE_SIZE^2 (2916) consecutive w_en cycles. The last address is origin + (TILE_SIZE-1)*SCREEN_W + (TILE_SIZE-1).
- Clear produces SCREEN_W*SCREEN_H (72900) consecutive w_en cycles, addresses 0..72899 ascending.
- PAINT -> DONE after the last write.
- In DONE: w_en=0, done=1 for exactly one cycle, w_addr holds the last value. DONE -> IDLE unconditionally, so req_ready rises the following cycle.
- Back-to-back requests: minimum spacing is the paint length + 2 cycles. A req_valid held high across completion is accepted in the first IDLE cycle.
- Counters: x,y are 9 bits (cover 0..269); address arithmetic is ADDR_W bits and never wraps for legal parameters.
- Input changes while busy are ignored.
- w_data is a registered colour, valid whenever w_en=1.

Optional Feature:
- Macro: TILE_BORDER_EN.
- Defined: during tile paints, pixels with x==0, x==TILE_SIZE-1, y==0 or y==TILE_SIZE-1 (tile-local) are written with BORDER_COLOR; all other pixels get req_color. Clear ignores the border. Timing and write count are unchanged.
- Undefined: every pixel is written with req_color; BORDER_COLOR is unused.

Test Plan:
- Reset release -> req_ready=1, w_en=0, done=0, w_addr=0.
- Tile (0,0), colour 8'hE0 -> w_en high 2916 consecutive cycles starting the cycle after accept. First addr 0; addr 54 never written; row 2 starts at 270; last addr 14363, all data E0. done pulses the next cycle; req_ready=1 one cycle later.
- Tile (4,4), colour 8'h1C -> first addr 58536, last addr 72899, 2916 writes. With TILE_BORDER_EN: addr 58536 data FF, addr 58806+1=58807 data 1C.
- Tile (5,0) -> zero w_en cycles; done=1 and err=1 together, the cycle after accept.
- req_clear=1, colour 8'h00 -> 72900 writes, addresses 0..72899 strictly ascending by 1, then a done pulse.
- Reset asserted after 100 writes of tile (1,2) -> w_en=0 asynchronously. After release req_ready=1 and no done pulse. A new tile (2,1) request then paints normally from origin 14688.
